// File: rtl/isa_pkg.sv
// Shared ISA definitions: instruction encoding constants and the fetch
// sequencer state type.
package isa_pkg;

    localparam int INST_W = 9;

    // Instruction word layout: [8:6] opcode, [5:4] field a, [3:2] field b, [1:0] field c.
    localparam int OPCODE_W   = 3;
    localparam int OPCODE_LSB = 6;
    localparam int FIELD_W    = 2;
    localparam int FIELD_A_LSB = 4;
    localparam int FIELD_B_LSB = 2;
    localparam int FIELD_C_LSB = 0;

    localparam logic [INST_W-1:0] HALT_WORD = 9'b111_11_11_11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Program counter owner: drives the ROM address, registers one instruction
// per cycle into the issue slot, and handles start, stall, redirect and halt.
module fetch_sequencer
    import isa_pkg::*;
#(
    parameter int A = 16,
    parameter int W = INST_W
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic         Stall,
    input  logic         BranchTaken,
    input  logic [A-1:0] BranchTarget,
    input  logic [W-1:0] InstOut,
    output logic [A-1:0] InstAddress,
    output logic [W-1:0] Inst,
    output logic         InstValid,
    output logic         Busy,
    output logic         Done,
    output logic [15:0]  InstCount
);

    fetch_state_t state_q, state_d;
    logic [A-1:0] pc_q, pc_d;
    logic [W-1:0] inst_q, inst_d;
    logic         valid_q, valid_d;
    logic         done_q, done_d;
    logic [15:0]  count_q, count_d;

    // NOTE: every next-state signal gets a default before the case, so no
    // path through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = 1'b0;
        done_d  = done_q;
        count_d = count_q;

        unique case (state_q)
            IDLE: begin
                pc_d = '0;
                if (Start) begin
                    state_d = RUN;
                    count_d = '0;
                end
            end

            RUN: begin
                if (Stall) begin
                    // hold everything; redirect request stays pending upstream
                end else if (BranchTaken) begin
                    pc_d = BranchTarget;
                end else if (InstOut == W'(HALT_WORD)) begin
                    state_d = HALT;
                    done_d  = 1'b1;
                end else begin
                    inst_d  = InstOut;
                    valid_d = 1'b1;
                    pc_d    = pc_q + A'(1);
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                end
            end

            HALT: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    count_d = '0;
                    done_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other, independent of block order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign InstAddress = pc_q;
    assign Inst        = inst_q;
    assign InstValid   = valid_q;
    assign Busy        = (state_q == RUN);
    assign Done        = done_q;
    assign InstCount   = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a 16-word behavioural ROM (A=4).
module tb_fetch_sequencer;

    localparam int A = 4;
    localparam int W = 9;

    logic         Clk;
    logic         Reset_n;
    logic         Start;
    logic         Stall;
    logic         BranchTaken;
    logic [A-1:0] BranchTarget;
    logic [W-1:0] InstOut;
    logic [A-1:0] InstAddress;
    logic [W-1:0] Inst;
    logic         InstValid;
    logic         Busy;
    logic         Done;
    logic [15:0]  InstCount;

    logic [W-1:0] rom [16];

    int vectors;
    int miscompares;

    fetch_sequencer #(.A(A), .W(W)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .InstOut      (InstOut),
        .InstAddress  (InstAddress),
        .Inst         (Inst),
        .InstValid    (InstValid),
        .Busy         (Busy),
        .Done         (Done),
        .InstCount    (InstCount)
    );

    assign InstOut = rom[InstAddress];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and return on the following falling edge.
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic check_issue(input string tag, input logic [W-1:0] exp_inst,
                               input logic [A-1:0] exp_addr, input logic [15:0] exp_cnt);
        check({tag, ".valid"}, InstValid, 1);
        check({tag, ".inst"}, Inst, exp_inst);
        check({tag, ".addr"}, InstAddress, exp_addr);
        check({tag, ".count"}, InstCount, exp_cnt);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        Reset_n      = 1'b0;
        Start        = 1'b0;
        Stall        = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = '0;
        for (int i = 0; i < 16; i++) rom[i] = 9'h0AA;
        for (int i = 0; i < 8; i++) rom[i] = 9'h010 + 9'(i);
        rom[8] = 9'h1FF;

        // Reset state
        step();
        check("rst.addr", InstAddress, 0);
        check("rst.inst", Inst, 0);
        check("rst.valid", InstValid, 0);
        check("rst.busy", Busy, 0);
        check("rst.done", Done, 0);
        check("rst.count", InstCount, 0);
        Reset_n = 1'b1;
        step();
        step();
        check("idle.busy", Busy, 0);
        check("idle.valid", InstValid, 0);

        // Start, eight instructions, halt at address 8
        Start = 1'b1;
        step();
        Start = 1'b0;
        check("start.busy", Busy, 1);
        check("start.addr", InstAddress, 0);
        check("start.valid", InstValid, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            check_issue("run", 9'h010 + 9'(i), A'(i + 1), 16'(i + 1));
        end
        step();
        check("halt.done", Done, 1);
        check("halt.valid", InstValid, 0);
        check("halt.busy", Busy, 0);
        check("halt.addr", InstAddress, 8);
        check("halt.count", InstCount, 8);
        check("halt.inst", Inst, 9'h017);
        step();
        check("halt.hold_done", Done, 1);
        check("halt.hold_addr", InstAddress, 8);

        // Restart from HALT, then stall at PC=3
        Start = 1'b1;
        step();
        Start = 1'b0;
        check("restart.done", Done, 0);
        check("restart.busy", Busy, 1);
        check("restart.addr", InstAddress, 0);
        check("restart.count", InstCount, 0);
        step();
        step();
        step();
        check_issue("pre_stall", 9'h012, 3, 3);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.addr", InstAddress, 3);
            check("stall.valid", InstValid, 0);
            check("stall.inst", Inst, 9'h012);
            check("stall.count", InstCount, 3);
        end
        Stall = 1'b0;
        step();
        check_issue("post_stall", 9'h013, 4, 4);

        // Taken branch at PC=6 to target 2
        step();
        step();
        check("pre_br.addr", InstAddress, 6);
        BranchTaken  = 1'b1;
        BranchTarget = 4'd2;
        step();
        BranchTaken = 1'b0;
        check("br.addr", InstAddress, 2);
        check("br.valid", InstValid, 0);
        check("br.inst", Inst, 9'h015);
        check("br.count", InstCount, 6);
        step();
        check_issue("br_tgt0", 9'h012, 3, 7);
        step();
        check_issue("br_tgt1", 9'h013, 4, 8);

        // Stall+branch at halt word, then branch wins over halt
        for (int i = 0; i < 4; i++) step();
        check("pre_hb.addr", InstAddress, 8);
        Stall        = 1'b1;
        BranchTaken  = 1'b1;
        BranchTarget = 4'd1;
        step();
        check("stall_br.addr", InstAddress, 8);
        check("stall_br.done", Done, 0);
        check("stall_br.busy", Busy, 1);
        Stall = 1'b0;
        step();
        BranchTaken = 1'b0;
        check("br_halt.addr", InstAddress, 1);
        check("br_halt.done", Done, 0);
        check("br_halt.valid", InstValid, 0);
        step();
        check_issue("br_halt_tgt", 9'h011, 2, 13);

        // Reset asserted mid-run at PC=5
        step();
        step();
        step();
        check("pre_rst.addr", InstAddress, 5);
        #2 Reset_n = 1'b0;
        #1;
        check("mid_rst.addr", InstAddress, 0);
        check("mid_rst.valid", InstValid, 0);
        check("mid_rst.done", Done, 0);
        check("mid_rst.busy", Busy, 0);
        check("mid_rst.count", InstCount, 0);
        step();
        Reset_n = 1'b1;
        step();
        step();
        check("post_rst.busy", Busy, 0);
        check("post_rst.addr", InstAddress, 0);
        check("post_rst.valid", InstValid, 0);

        // PC wrap and count saturation with a halt-free ROM
        for (int i = 0; i < 16; i++) rom[i] = 9'h0A0 + 9'(i);
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int n = 1; n <= 65540; n++) begin
            step();
            if (n == 15) check_issue("wrap15", 9'h0AE, 15, 15);
            if (n == 16) check_issue("wrap16", 9'h0AF, 0, 16);
            if (n == 17) check_issue("wrap17", 9'h0A0, 1, 17);
            if (n == 65534) check("sat.fffe", InstCount, 16'hFFFE);
            if (n == 65535) check("sat.ffff", InstCount, 16'hFFFF);
            if (n == 65540) check_issue("sat.hold", 9'h0A3, 4, 16'hFFFF);
        end

        // Halt, then Start from HALT restarts at 0
        rom[4] = 9'h1FF;
        step();
        check("halt2.done", Done, 1);
        check("halt2.addr", InstAddress, 4);
        check("halt2.count", InstCount, 16'hFFFF);
        Start = 1'b1;
        step();
        Start = 1'b0;
        check("restart2.done", Done, 0);
        check("restart2.busy", Busy, 1);
        check("restart2.addr", InstAddress, 0);
        check("restart2.count", InstCount, 0);
        step();
        check_issue("restart2.issue", 9'h0A0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
